fetch_prefetch_queue: RTL
=========================

Name: fetch_prefetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues single-outstanding requests to instruction memory. Returned words are buffered with their PC+4 in a small FIFO, which IF/ID drains through a valid/ready handshake. Branch/jump redirects from decode flush the queue and restart fetch at the new PC.

Parameters:
DEPTH, 4, FIFO entries (power of 2, ≥2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
imem_req  out  1  instruction-memory request valid
imem_addr  out  32  request address (word-aligned)
imem_ack  in  1  response valid for the outstanding request
imem_rdata  in  32  instruction word, valid with imem_ack
redirect  in  1  decode-stage PC redirect (taken branch/jump)
redirect_pc  in  32  new fetch address
out_valid  out  1  queue head valid
out_ready  in  1  IF/ID accepts head (deasserted on stall)
out_instr  out  32  head instruction
out_pc_incr  out  32  head PC+4

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC; state=F_IDLE; FIFO empty; imem_req=0; imem_addr=RESET_PC; out_valid=0; out_instr=0; out_pc_incr=0.
- States: F_IDLE (no request outstanding), F_WAIT (request outstanding, response kept), F_DISCARD (request outstanding, response dropped).
- Request issue: at an edge where the post-edge FIFO count is < DEPTH and no request remains outstanding, set imem_req=1, imem_addr=fetch_pc, go F_WAIT. The first request is issued on the first edge after reset is released.
- imem_req and imem_addr hold stable until imem_ack. A request is never withdrawn.
- imem_ack may assert in the first cycle imem_req is high. This gives a sustained throughput of 1 instruction/cycle.
- Ack in F_WAIT: enqueue {imem_rdata, imem_addr+4}, then fetch_pc=imem_addr+4. The next request may issue on the same edge, with imem_req staying 1 and the address updated.
- imem_ack while imem_req=0 is ignored.
- Output: out_valid=(count!=0). out_instr and out_pc_incr come from the head entry and are 0 when empty. The head is popped at an edge where out_valid&&out_ready.
- Latency: a word acked at edge N is visible at the head after edge N when the queue was empty.
- Simultaneous push and pop when full: both occur and count is unchanged. Push cannot overflow, because issue already guarantees space.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Redirect (highest priority) at an edge:
  - FIFO cleared and any pop ignored; fetch_pc=redirect_pc.
  - Request outstanding and no ack this edge: go F_DISCARD, keep imem_req/imem_addr until ack, drop that data, then issue redirect_pc.
  - Ack on the same edge as redirect: data dropped, redirect_pc issued on that edge.
  - Redirect in F_DISCARD: only fetch_pc is updated.
- redirect_pc[1:0] is ignored (forced to 0).
- Reset mid-request: all state cleared immediately. A late ack after reset is ignored because imem_req=0.

Optional Feature:
Macro PREFETCH_JUMP_PREDECODE_EN.
- Defined: on an accepted (not discarded) ack where imem_rdata[31:26]==6'h02 (J), set next fetch_pc={pc_incr[31:28], imem_rdata[25:0], 2'b00}, where pc_incr=imem_addr+4. The J word is still enqueued normally.
- Not defined: fetch is always sequential (imem_addr+4); jumps are resolved only by redirect.

Decomposition:
- Shared package mips_fetch_pkg holds:
  - fetch state enum {F_IDLE, F_WAIT, F_DISCARD}
  - OPC_J=6'h02
  - INSTR_W=32
  - DEFAULT_FETCH_DEPTH=4
- One sub-module, fetch_fifo: synchronous FIFO with a flush input, push/pop, count, and head read. The top contains only the FSM and PC logic.

Test Plan:
- Reset, then ack on every cycle while out_ready=1 → imem_addr 0,4,8,...; out_instr follows the memory contents, out_pc_incr=4,8,12; one instruction accepted per cycle.
- out_ready=0 with acks every cycle → exactly 4 words enqueued, imem_req=0 after the fourth ack; out_ready=1 for one cycle → one new request issued at address 16.
- Request to 8 outstanding, redirect=1 with redirect_pc=0x100, ack delayed 3 cycles → imem_addr stays 8 until ack; the word is dropped; next request goes to 0x100; out_valid=0 throughout.
- Redirect and ack on the same edge with queue full and out_ready=1 → queue empty, no pop counted, next imem_addr=redirect_pc.
- rst asserted while F_WAIT with 2 entries queued → imem_req=0, out_valid=0 immediately; after release, the first request goes to RESET_PC.
- With PREFETCH_JUMP_PREDECODE_EN, word 0x0800_0040 acked at address 0x0 → next imem_addr=0x100. Without the macro → next imem_addr=0x4.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// -----------------------------------------------------------------------------
// mips_fetch_pkg
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_t : fetch FSM states (idle / waiting / discarding a response)
//   fetch_entry_t : one prefetch-queue entry {instruction, PC+4}
//   next_fetch_pc : sequential or J-predecoded next fetch address
// -----------------------------------------------------------------------------
package mips_fetch_pkg;

    localparam int         INSTR_W             = 32;
    localparam int         DEFAULT_FETCH_DEPTH = 4;
    localparam logic [5:0] OPC_J               = 6'h02;

    typedef enum logic [1:0] {
        F_IDLE    = 2'd0,   // no request outstanding
        F_WAIT    = 2'd1,   // request outstanding, response will be kept
        F_DISCARD = 2'd2    // request outstanding, response will be dropped
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc_incr;
    } fetch_entry_t;

    // Address to fetch after an accepted word. With jump_en set, a J
    // instruction redirects fetch to its pseudo-direct target; otherwise
    // fetch simply continues at PC+4.
    function automatic logic [INSTR_W-1:0] next_fetch_pc(
        input logic [INSTR_W-1:0] pc_incr,
        input logic [INSTR_W-1:0] instr,
        input logic               jump_en
    );
        if (jump_en && (instr[31:26] == OPC_J))
            return {pc_incr[31:28], instr[25:0], 2'b00};
        return pc_incr;
    endfunction

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding fetched {instruction, PC+4} entries.
// Ports:
//   i_clk, i_rst      : clock (rising edge), async active-high reset
//   i_flush           : clear the queue; overrides push and pop on this edge
//   i_push/i_push_data: enqueue one entry
//   i_pop             : dequeue the head entry (ignored when empty)
//   o_count           : number of entries held (0..DEPTH)
//   o_head            : head entry, all-zero when empty
// Push and pop on the same edge are both honoured, including when full.
// -----------------------------------------------------------------------------
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_FETCH_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    output logic [CW-1:0] o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty && !i_flush;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign w_push  = i_push && !i_flush && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: entries are only visible through r_count.
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_queue
// Instruction-fetch front end feeding the IF/ID register. Owns the fetch PC,
// keeps at most one instruction-memory request outstanding, and buffers
// returned words with their PC+4 in a fetch_fifo drained by IF/ID.
// Ports:
//   i_clk, i_rst       : clock (rising edge), async active-high reset
//   o_imem_req         : request valid; held with o_imem_addr until i_imem_ack
//   o_imem_addr        : word-aligned request address
//   i_imem_ack         : response for the outstanding request (ignored if idle)
//   i_imem_rdata       : instruction word, valid with i_imem_ack
//   i_redirect         : taken branch/jump from decode; flushes the queue
//   i_redirect_pc      : new fetch address (bits [1:0] ignored)
//   o_out_valid        : queue head valid
//   i_out_ready        : IF/ID accepts the head
//   o_out_instr        : head instruction (0 when empty)
//   o_out_pc_incr      : head PC+4 (0 when empty)
//   o_dbg_state        : current fetch FSM state
// Handshake: the head leaves the queue at a rising edge where o_out_valid and
// i_out_ready are both high and i_redirect is low; o_out_valid never depends
// on i_out_ready.
// Build option: PREFETCH_JUMP_PREDECODE_EN makes accepted J instructions
// steer fetch to their target; without it fetch is strictly sequential.
// -----------------------------------------------------------------------------
module fetch_prefetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_FETCH_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic         o_imem_req,
    output logic [31:0]  o_imem_addr,
    input  logic         i_imem_ack,
    input  logic [31:0]  i_imem_rdata,
    input  logic         i_redirect,
    input  logic [31:0]  i_redirect_pc,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [31:0]  o_out_instr,
    output logic [31:0]  o_out_pc_incr,
    output fetch_state_t o_dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;

`ifdef PREFETCH_JUMP_PREDECODE_EN
    localparam logic JUMP_EN = 1'b1;
`else
    localparam logic JUMP_EN = 1'b0;
`endif

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_req_addr;

    logic         w_busy;
    logic         w_ack;
    logic         w_accept;
    logic         w_pop;
    logic         w_still_out;
    logic         w_issue;
    logic [31:0]  w_pc_incr;
    logic [31:0]  w_seq_pc;
    logic [31:0]  w_redirect_pc;
    logic [31:0]  w_fetch_pc_next;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    fetch_entry_t w_push_data;
    fetch_entry_t w_head;

    assign w_busy        = (r_state != F_IDLE);
    assign w_ack         = i_imem_ack && w_busy;
    // Only a response in F_WAIT with no redirect on the same edge is kept.
    assign w_accept      = w_ack && (r_state == F_WAIT) && !i_redirect;
    assign w_pop         = o_out_valid && i_out_ready && !i_redirect;
    assign w_still_out   = w_busy && !i_imem_ack;
    assign w_pc_incr     = r_req_addr + 32'd4;
    assign w_seq_pc      = next_fetch_pc(w_pc_incr, i_imem_rdata, JUMP_EN);
    assign w_redirect_pc = i_redirect_pc & ~32'h3;

    assign w_push_data.instr   = i_imem_rdata;
    assign w_push_data.pc_incr = w_pc_incr;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (i_redirect),
        .i_push      (w_accept),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    // Queue occupancy after this edge; issue only needs space in it.
    always_comb begin
        w_count_next = w_count;
        if (i_redirect) begin
            w_count_next = '0;
        end else begin
            if (w_accept)
                w_count_next = w_count_next + 1'b1;
            if (w_pop)
                w_count_next = w_count_next - 1'b1;
        end
    end

    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (i_redirect)
            w_fetch_pc_next = w_redirect_pc;
        else if (w_accept)
            w_fetch_pc_next = w_seq_pc;
    end

    // FSM: state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= F_IDLE;
        else
            r_state <= w_state_next;
    end

    // FSM: next state. A new request may go out on the same edge that the
    // previous one completes, which sustains one word per cycle.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        if (w_still_out) begin
            // A redirect while waiting turns the pending response into garbage.
            if (i_redirect)
                w_state_next = F_DISCARD;
        end else if (w_count_next < CW'(DEPTH)) begin
            w_issue      = 1'b1;
            w_state_next = F_WAIT;
        end else begin
            w_state_next = F_IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        o_imem_req  = (r_state != F_IDLE);
        o_dbg_state = r_state;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_fetch_pc <= w_fetch_pc_next;
            if (w_issue)
                r_req_addr <= w_fetch_pc_next;
        end
    end

    assign o_imem_addr   = r_req_addr;
    assign o_out_valid   = (w_count != '0);
    assign o_out_instr   = w_head.instr;
    assign o_out_pc_incr = w_head.pc_incr;

endmodule
